instr_encoder: RTL and testbench

Instruction encoder and issue buffer for the execution unit. It accepts decoded-form operation requests (mnemonic code plus register and immediate fields) and packs each one into the 32-bit R-type or I-type instruction word that the execution unit decodes. Encoded words are buffered in a small FIFO and issued over a valid/ready handshake. It sits between the test or program sequencer and the ALU/register-file block.

---
 rtl/instr_pkg.sv | 69 ++++++
 rtl/instr_fifo.sv | 72 +++++++
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: shared definitions for the instruction encoder and the execution
// unit that decodes its output.
//   - op_e        : request operation codes (req_op)
//   - fmt_e       : R/I instruction format
//   - fifo_state_e: block-level issue buffer state, derived from occupancy
//   - opcode/funct values and instruction field bit positions
package instr_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBU  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_SLT   = 4'd8,
        OP_ADDI  = 4'd9,
        OP_ADDIU = 4'd10,
        OP_ANDI  = 4'd11,
        OP_ORI   = 4'd12,
        OP_SLTI  = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_e;

    typedef enum logic {
        FMT_R = 1'b0,
        FMT_I = 1'b1
    } fmt_e;

    typedef enum logic [1:0] {
        FS_EMPTY   = 2'd0,
        FS_PARTIAL = 2'd1,
        FS_FULL    = 2'd2
    } fifo_state_e;

    // R-type funct values
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // I-type opcodes; R-type uses the special opcode 0
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    // Field LSB positions within the 32-bit word
    localparam int POS_OPC   = 26;
    localparam int POS_RS    = 21;
    localparam int POS_RT    = 16;
    localparam int POS_RD    = 11;
    localparam int POS_SHAMT = 6;
    localparam int POS_FUNCT = 0;
    localparam int POS_IMM   = 0;

    localparam int INSTR_W = 32;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: issue buffer holding encoded instruction words.
// Parameters: DEPTH (power of two, >= 2), W (word width).
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears storage too,
//                 so rdata reads 0 when empty after reset)
//   push, wdata : write a word; ignored when full
//   pop         : drop the head word; ignored when empty
//   rdata       : head word
//   full, empty : occupancy flags
module instr_fifo
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr, rptr;
    logic [CW-1:0]           count;
    fifo_state_e             state;
    logic                    do_push, do_pop;

    always_comb begin
        state = FS_PARTIAL;
        if (count == '0)
            state = FS_EMPTY;
        else if (count == CW'(DEPTH))
            state = FS_FULL;
    end

    assign full  = (state == FS_FULL);
    assign empty = (state == FS_EMPTY);

    // A full FIFO refuses the push even if the head is popped this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded operation requests into 32-bit R/I-type words,
// buffers them and issues them over a valid/ready handshake.
// Optional feature macro: INSTR_ENC_LEGAL_CHECK_EN (reject illegal ops and
// writes to register 0, pulsing err; otherwise err is 0 and illegal ops
// encode as NOP).
// Parameters: DEPTH (FIFO entries), CNT_W (issued counter width).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_op, req_rd, req_rs,
//   req_rt, req_shamt, req_imm    : decoded request fields
//   instr_valid/instr_ready       : issue handshake
//   instr_data                    : encoded word at FIFO head
//   err                           : one-cycle pulse after a rejected request
//   issued_cnt                    : words handed off, wrapping
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs,
    input  logic [4:0]       req_rt,
    input  logic [4:0]       req_shamt,
    input  logic [15:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_data,
    output logic             err,
    output logic [CNT_W-1:0] issued_cnt
);

    logic        full, empty;
    logic        accept, push, pop;
    logic [31:0] enc_word;
    logic [5:0]  funct, opc;
    fmt_e        fmt;
    logic        is_shift;
    logic        legal_op;

    // Decode the op into format and function/opcode fields.
    always_comb begin
        funct    = FN_ADD;
        opc      = OPC_RTYPE;
        fmt      = FMT_R;
        is_shift = 1'b0;
        legal_op = 1'b1;
        case (op_e'(req_op))
            OP_ADD:   funct = FN_ADD;
            OP_ADDU:  funct = FN_ADDU;
            OP_SUB:   funct = FN_SUB;
            OP_SUBU:  funct = FN_SUBU;
            OP_AND:   funct = FN_AND;
            OP_OR:    funct = FN_OR;
            OP_SLL:   begin funct = FN_SLL; is_shift = 1'b1; end
            OP_SRL:   begin funct = FN_SRL; is_shift = 1'b1; end
            OP_SLT:   funct = FN_SLT;
            OP_ADDI:  begin fmt = FMT_I; opc = OPC_ADDI;  end
            OP_ADDIU: begin fmt = FMT_I; opc = OPC_ADDIU; end
            OP_ANDI:  begin fmt = FMT_I; opc = OPC_ANDI;  end
            OP_ORI:   begin fmt = FMT_I; opc = OPC_ORI;   end
            OP_SLTI:  begin fmt = FMT_I; opc = OPC_SLTI;  end
            default:  legal_op = 1'b0;
        endcase
    end

    // Assemble the word. Shifts take their source from rs and zero rt;
    // everything else zeroes shamt. Illegal ops become an all-zero NOP.
    always_comb begin
        enc_word = '0;
        if (legal_op) begin
            if (fmt == FMT_R) begin
                enc_word[POS_OPC+:6]   = OPC_RTYPE;
                enc_word[POS_RS+:5]    = req_rs;
                enc_word[POS_RT+:5]    = is_shift ? 5'd0 : req_rt;
                enc_word[POS_RD+:5]    = req_rd;
                enc_word[POS_SHAMT+:5] = is_shift ? req_shamt : 5'd0;
                enc_word[POS_FUNCT+:6] = funct;
            end else begin
                enc_word[POS_OPC+:6]  = opc;
                enc_word[POS_RS+:5]   = req_rs;
                enc_word[POS_RT+:5]   = req_rt;
                enc_word[POS_IMM+:16] = req_imm;
            end
        end
    end

    assign req_ready   = !full;
    assign accept      = req_valid && req_ready;
    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    logic dest_zero;
    logic legal;

    assign dest_zero = (fmt == FMT_R) ? (req_rd == 5'd0) : (req_rt == 5'd0);
    assign legal     = legal_op && !dest_zero;

    // Rejected requests still complete the handshake; they are just dropped.
    assign push = accept && legal;

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else
            err <= accept && !legal;
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            issued_cnt <= '0;
        else if (pop)
            issued_cnt <= issued_cnt + CNT_W'(1);
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (instr_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [3:0]       req_op;
    logic [4:0]       req_rd, req_rs, req_rt, req_shamt;
    logic [15:0]      req_imm;
    logic             instr_valid, instr_ready;
    logic [31:0]      instr_data;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_shamt   (req_shamt),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .err         (err),
        .issued_cnt  (issued_cnt)
    );

    // Reference: funct per R-type op 0..8, opcode per I-type op 9..13.
    localparam int RF[9] = '{32, 33, 34, 35, 36, 37, 0, 2, 42};
    localparam int IO[5] = '{8, 9, 12, 13, 10};

    function automatic logic [31:0] ref_enc(int op, int rd, int rs, int rt, int sh, int imm);
        int w;
        if (op < 9) begin
            if (op == 6 || op == 7) rt = 0;
            else sh = 0;
            w = rs * (2**21) + rt * (2**16) + rd * (2**11) + sh * 64 + RF[op];
        end else if (op < 14) begin
            w = IO[op-9] * (2**26) + rs * (2**21) + rt * (2**16) + imm;
        end else begin
            w = 0;
        end
        return w;
    endfunction

    function automatic bit ref_ok(int op, int rd, int rt);
        if (!CHK_EN) return 1'b1;
        if (op >= 14) return 1'b0;
        return (op < 9) ? (rd != 0) : (rt != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int op, input int rd, input int rs, input int rt,
                           input int sh, input int imm);
        req_op    = 4'(op);
        req_rd    = 5'(rd);
        req_rs    = 5'(rs);
        req_rt    = 5'(rt);
        req_shamt = 5'(sh);
        req_imm   = 16'(imm);
    endtask

    typedef struct {
        int          op, rd, rs, rt, sh, imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    logic [31:0] q[$];
    logic [31:0] fillexp[5];
    bit          exp_err;

    initial begin
        rst = 1'b1; req_valid = 1'b0; instr_ready = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);

        // Directed single-word vectors
        vecs[0] = '{0, 3, 16, 17, 0, 0, 32'h02111820};
        vecs[1] = '{9, 0, 16, 5, 0, 16'h0007, 32'h22050007};
        vecs[2] = '{12, 0, 0, 2, 0, 16'hFFFF, 32'h3402FFFF};
        vecs[3] = '{6, 4, 17, 9, 3, 0, 32'h022020C0};
        vecs[4] = '{2, 1, 2, 3, 7, 0, 32'h00430822};
        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].sh, vecs[i].imm);
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), instr_data, vecs[i].exp);
            instr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            instr_ready = 1'b0;
            exp_cnt++;
            chk($sformatf("vec%0d_drained", i), 32'(instr_valid), 32'd0);
            chk($sformatf("vec%0d_cnt", i), 32'(issued_cnt), 32'(exp_cnt));
        end

        // Fill past capacity with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            set_req(i % 9, i + 1, i + 10, i + 20, 0, 0);
            fillexp[i] = ref_enc(i % 9, i + 1, i + 10, i + 20, 0, 0);
            req_valid = 1'b1;
            chk($sformatf("fill%0d_ready", i), 32'(req_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("fill_held_data", instr_data, fillexp[0]);
        instr_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_data", i), instr_data, fillexp[i]);
            @(posedge clk);
            @(negedge clk);
            exp_cnt++;
        end
        instr_ready = 1'b0;
        chk("drain_empty", 32'(instr_valid), 32'd0);
        chk("drain_cnt", 32'(issued_cnt), 32'(exp_cnt));
        set_req(4, 5, 14, 24, 0, 0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fifth_data", instr_data, fillexp[4]);
        instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        exp_cnt++;
        chk("fifth_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Illegal op 14
        set_req(14, 7, 1, 2, 0, 0);
        req_valid = 1'b1;
        chk("ill_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (CHK_EN) begin
            chk("ill_err", 32'(err), 32'd1);
            chk("ill_not_enq", 32'(instr_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("ill_err_pulse", 32'(err), 32'd0);
        end else begin
            chk("ill_err", 32'(err), 32'd0);
            chk("ill_valid", 32'(instr_valid), 32'd1);
            chk("ill_nop", instr_data, 32'd0);
            instr_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            instr_ready = 1'b0;
            exp_cnt++;
            chk("ill_cnt", 32'(issued_cnt), 32'(exp_cnt));
        end

        // Reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            set_req(1, i + 1, 2, 3, 0, 0);
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("prerst_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_cnt", 32'(issued_cnt), 32'd0);
        chk("midrst_data", instr_data, 32'd0);

        // Randomized traffic against a queue model
        exp_cnt = 0;
        exp_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int op, rd, rs, rt, sh, imm;
            bit v, r, acc, pop;
            chk("rnd_valid", 32'(instr_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("rnd_data", instr_data, q[0]);
            chk("rnd_ready", 32'(req_ready), 32'(q.size() < DEPTH));
            chk("rnd_err", 32'(err), 32'(exp_err));
            chk("rnd_cnt", 32'(issued_cnt), 32'(exp_cnt % (2**CNT_W)));
            op  = $urandom_range(0, 15);
            rd  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 31);
            rs  = $urandom_range(0, 31);
            rt  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 31);
            sh  = $urandom_range(0, 31);
            imm = $urandom_range(0, 65535);
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2) != 0);
            set_req(op, rd, rs, rt, sh, imm);
            req_valid   = v;
            instr_ready = r;
            acc = v && (q.size() < DEPTH);
            pop = r && (q.size() > 0);
            exp_err = acc && !ref_ok(op, rd, rt);
            if (pop) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (acc && ref_ok(op, rd, rt)) q.push_back(ref_enc(op, rd, rs, rt, sh, imm));
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        instr_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
